fetch_sequencer: RTL
====================

# fetch_sequencer

Multi-cycle fetch/execute controller for the 8-bit CPU datapath. It fetches each 16-bit instruction as two bytes from a byte-wide instruction memory with a ready handshake, and presents the assembled word on the CPU's `Iin`. It stretches load/store instructions until data memory acknowledges, then issues a one-cycle `STEP` that the CPU uses to gate its PC and register-file updates. A bounded wait timer latches a sticky fault if any memory stalls too long.

## Interface
- `WAIT_MAX`, default 8: maximum consecutive not-ready cycles per request before fault; 0 disables the timeout.
- `CLK` in 1: system clock, rising edge.
- `RESET_L` in 1: asynchronous, active-low reset.
- `EN_L` in 1: active-low run enable; sampled only at instruction boundaries.
- `PC` in 8: current CPU program counter; only changes on a `STEP` edge.
- `IADDR` out 8: instruction byte address.
- `IREQ` out 1: instruction read request.
- `IRDY` in 1: instruction memory ready; data valid on `IDATA` when high.
- `IDATA` in 8: instruction byte.
- `DREQ` out 1: data access request for the load or store in `Iout`.
- `DRDY` in 1: data memory ready.
- `Iout` out 16: assembled instruction, driving the CPU's `Iin`.
- `STEP` out 1: one-cycle commit pulse to the CPU.
- `BUSY` out 1: high in every state except IDLE and FAULT.
- `FAULT` out 1: sticky timeout flag.

## Operation
- States: IDLE, FETCH_HI, FETCH_LO, MEM, EXEC, FAULT.
- **IDLE**
  - `EN_L`=0 goes to FETCH_HI.
  - `EN_L`=1 stays in IDLE.
- **FETCH_HI**
  - `IREQ`=1 and `IADDR`=`PC`.
  - On `IRDY`=1, capture `IDATA` into the high holding byte and go to FETCH_LO.
- **FETCH_LO**
  - `IREQ`=1 and `IADDR`=`PC`+1, modulo 256, so `PC`=0xFF fetches 0x00.
  - On `IRDY`=1, `Iout` <= {high holding byte, `IDATA`}; this is big-endian.
  - Next state is MEM if `IDATA`-assembled opcode [15:12] is 4'b0010 (load) or 4'b0100 (store); otherwise EXEC.
- **MEM**
  - `DREQ`=1.
  - On `DRDY`=1 go to EXEC.
- **EXEC**
  - `STEP`=1 for exactly this cycle.
  - Next state is FETCH_HI if `EN_L`=0, else IDLE.
- **FAULT**
  - `FAULT`=1; `IREQ`, `DREQ` and `STEP` are 0.
  - Only reset exits this state.
- **Enable handling:** `EN_L` rising mid-instruction does not abort; the instruction completes through EXEC.
- **Wait timer:**
  - Clears on every state change.
  - Increments on each cycle in FETCH_HI, FETCH_LO or MEM while the relevant ready is 0.
  - If ready is 0 for `WAIT_MAX` consecutive cycles in one state, go to FAULT at that edge.
  - Ready arriving in cycle `WAIT_MAX` is accepted, with no fault.
  - Width is clog2(`WAIT_MAX`+1).
- **Output sourcing:**
  - `IREQ`, `DREQ`, `STEP`, `BUSY`, `FAULT` and `IADDR` decode combinationally from state and `PC`.
  - `Iout` is registered.

## Timing
- Reset values: state IDLE, `Iout`=16'h0000 (opcode 0, no register write), timer 0, high holding byte 0. `IREQ`=`DREQ`=`STEP`=`BUSY`=`FAULT`=0; `IADDR`=`PC`.
- Reset assertion takes effect immediately in any state, including mid-fetch and FAULT.
- After reset release, the first edge evaluates IDLE.
- Zero-wait memory, non-memory instruction: FETCH_HI, FETCH_LO, EXEC = 3 cycles per instruction in steady state.
- Zero-wait memory, load/store: 4 cycles per instruction.
- Each wait cycle on `IRDY`/`DRDY` adds exactly 1 cycle.
- `Iout` changes only at the FETCH_LO completion edge and is stable through MEM and EXEC.
- The CPU updates `PC` on the edge ending EXEC, so the next FETCH_HI sees the new `PC` with no bubble.
- `IREQ` holds with stable `IADDR` until `IRDY` is sampled high.
- `DREQ` holds until `DRDY` is sampled high.
- `IRDY` outside FETCH_HI/FETCH_LO is ignored; `DRDY` outside MEM is ignored.

## Structure
- Package `cpu_seq_pkg`:
  - state enum;
  - opcode constants `OP_LD`=4'b0010 and `OP_ST`=4'b0100;
  - reset instruction 16'h0000.
- Sub-module `wait_timer`:
  - inputs: clear, count-enable;
  - output: expired flag;
  - parameterized by `WAIT_MAX`.
- One FSM process plus one registered `Iout`/holding process.

## Test plan
- Zero-wait memory, `PC`=0x10, bytes 0x0F,0xC8 -> `Iout`=16'h0FC8 after 2 cycles, `STEP` in cycle 3, `IADDR` 0x10 then 0x11.
- Load 16'h2281 with `DRDY` delayed 2 cycles -> `DREQ` high 3 cycles, `STEP` exactly once, 6 cycles total.
- `PC`=0xFF -> `IADDR` sequence 0xFF, 0x00.
- `WAIT_MAX`=4, `IRDY` held 0 in FETCH_HI -> `FAULT`=1 after 4 cycles with `IREQ`=0; `IRDY` rising in cycle 4 instead -> no fault.
- `EN_L` raised during FETCH_LO -> instruction finishes, one `STEP`, then IDLE with `BUSY`=0.
- `RESET_L` pulsed low during MEM -> `DREQ`=0 and `Iout`=0 immediately; after release, a fresh fetch starts from `PC`.

Source files
------------

// File: rtl/cpu_seq_pkg.sv
// Shared types and constants for the fetch/execute sequencer of the 8-bit CPU.
package cpu_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_FETCH_HI = 3'd1,
        ST_FETCH_LO = 3'd2,
        ST_MEM      = 3'd3,
        ST_EXEC     = 3'd4,
        ST_FAULT    = 3'd5
    } seq_state_e;

    localparam logic [3:0]  OP_LD       = 4'b0010;
    localparam logic [3:0]  OP_ST       = 4'b0100;
    localparam logic [15:0] RESET_INSTR = 16'h0000;

    // Loads and stores need a data-memory phase before commit.
    function automatic logic is_mem_op(input logic [15:0] instr);
        return (instr[15:12] == OP_LD) || (instr[15:12] == OP_ST);
    endfunction

endpackage

// File: rtl/wait_timer.sv
// Consecutive not-ready cycle counter; flags expiry on the WAIT_MAX-th stalled cycle.
module wait_timer #(
    parameter int unsigned WAIT_MAX = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic count_en,
    output logic expired
);

    localparam int unsigned   CW      = (WAIT_MAX == 0) ? 1 : $clog2(WAIT_MAX + 1);
    localparam logic          ENABLED = (WAIT_MAX != 0) ? 1'b1 : 1'b0;
    localparam logic [CW-1:0] LIMIT   = (WAIT_MAX == 0) ? '0 : CW'(WAIT_MAX - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // Expiry must not depend on clear, since clear is derived from the next state.
    always_comb begin
        expired = ENABLED && count_en && (count_q == LIMIT);
    end

    // Next count: clear wins, otherwise count stalled cycles up to the limit.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (ENABLED && count_en && (count_q != LIMIT)) begin
            count_d = count_q + CW'(1);
        end else begin
            count_d = count_q;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Two-byte instruction fetch, optional data-memory stall, one-cycle STEP commit,
// with a sticky fault when any memory stalls past WAIT_MAX cycles.
module fetch_sequencer
    import cpu_seq_pkg::*;
#(
    parameter int unsigned WAIT_MAX = 8
) (
    input  logic        CLK,
    input  logic        RESET_L,
    input  logic        EN_L,
    input  logic [7:0]  PC,
    output logic [7:0]  IADDR,
    output logic        IREQ,
    input  logic        IRDY,
    input  logic [7:0]  IDATA,
    output logic        DREQ,
    input  logic        DRDY,
    output logic [15:0] Iout,
    output logic        STEP,
    output logic        BUSY,
    output logic        FAULT
);

    seq_state_e  state_q;
    seq_state_e  state_d;
    logic [7:0]  hi_q;
    logic [7:0]  hi_d;
    logic [15:0] iout_q;
    logic [15:0] iout_d;
    logic        wait_cnt_en_s;
    logic        timer_clear_s;
    logic        timer_expired_s;

    // Stall detection: the ready that matters depends on which request is open.
    always_comb begin
        wait_cnt_en_s = 1'b0;
        case (state_q)
            ST_FETCH_HI: wait_cnt_en_s = !IRDY;
            ST_FETCH_LO: wait_cnt_en_s = !IRDY;
            ST_MEM:      wait_cnt_en_s = !DRDY;
            default:     wait_cnt_en_s = 1'b0;
        endcase
    end

    // Restart the stall count whenever the sequencer moves on.
    always_comb begin
        timer_clear_s = (state_d != state_q);
    end

    wait_timer #(
        .WAIT_MAX (WAIT_MAX)
    ) u_wait_timer (
        .clk      (CLK),
        .rst_n    (RESET_L),
        .clear    (timer_clear_s),
        .count_en (wait_cnt_en_s),
        .expired  (timer_expired_s)
    );

    // State register.
    always_ff @(posedge CLK or negedge RESET_L) begin
        if (!RESET_L) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a granted ready always beats an expiring timer.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (!EN_L) state_d = ST_FETCH_HI;
                else       state_d = ST_IDLE;
            end
            ST_FETCH_HI: begin
                if (IRDY)                 state_d = ST_FETCH_LO;
                else if (timer_expired_s) state_d = ST_FAULT;
                else                      state_d = ST_FETCH_HI;
            end
            ST_FETCH_LO: begin
                if (IRDY)                 state_d = is_mem_op({hi_q, IDATA}) ? ST_MEM : ST_EXEC;
                else if (timer_expired_s) state_d = ST_FAULT;
                else                      state_d = ST_FETCH_LO;
            end
            ST_MEM: begin
                if (DRDY)                 state_d = ST_EXEC;
                else if (timer_expired_s) state_d = ST_FAULT;
                else                      state_d = ST_MEM;
            end
            ST_EXEC: begin
                if (EN_L) state_d = ST_IDLE;
                else      state_d = ST_FETCH_HI;
            end
            ST_FAULT: state_d = ST_FAULT;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Output decode from state and PC only.
    always_comb begin
        IADDR = PC;
        IREQ  = 1'b0;
        DREQ  = 1'b0;
        STEP  = 1'b0;
        BUSY  = 1'b0;
        FAULT = 1'b0;
        case (state_q)
            ST_FETCH_HI: begin
                IREQ = 1'b1;
                BUSY = 1'b1;
            end
            ST_FETCH_LO: begin
                IADDR = PC + 8'd1;
                IREQ  = 1'b1;
                BUSY  = 1'b1;
            end
            ST_MEM: begin
                DREQ = 1'b1;
                BUSY = 1'b1;
            end
            ST_EXEC: begin
                STEP = 1'b1;
                BUSY = 1'b1;
            end
            ST_FAULT: FAULT = 1'b1;
            default: begin
                IADDR = PC;
            end
        endcase
    end

    // Byte capture: high byte first, then the full word updates Iout in one step.
    always_comb begin
        hi_d   = hi_q;
        iout_d = iout_q;
        if ((state_q == ST_FETCH_HI) && IRDY) begin
            hi_d = IDATA;
        end else if ((state_q == ST_FETCH_LO) && IRDY) begin
            iout_d = {hi_q, IDATA};
        end else begin
            hi_d   = hi_q;
            iout_d = iout_q;
        end
    end

    // Holding byte and instruction register.
    always_ff @(posedge CLK or negedge RESET_L) begin
        if (!RESET_L) begin
            hi_q   <= 8'h00;
            iout_q <= RESET_INSTR;
        end else begin
            hi_q   <= hi_d;
            iout_q <= iout_d;
        end
    end

    assign Iout = iout_q;

endmodule
